// File: rtl/shared_add_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shared_add_arbiter_if                                        |
// | Description : Requester and response bundle of the shared adder arbiter.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface shared_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ci;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_co;
    logic [ID_W-1:0]          rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_ci, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ci, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id
    );
endinterface
`default_nettype wire

// File: rtl/shared_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shared_add_arbiter                                           |
// | Description : Round-robin share of one adder between NUM_REQ requesters,   |
// |               two-stage pipeline. SHARED_ADD_OPISO_EN adds operand         |
// |               isolation (registers and adder inputs idle when unused).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shared_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input wire                  clk,
    input wire                  rst_n,
    shared_add_arbiter_if.slave bus
);
    logic [ID_W-1:0]    r_ptr;
    logic               r_s1_v;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic               r_s1_ci;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_sum;
    logic               r_rsp_co;
    logic [ID_W-1:0]    r_rsp_id;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_above;
    logic [NUM_REQ-1:0] w_hi_req;
    logic [NUM_REQ-1:0] w_pick;
    logic [NUM_REQ-1:0] w_oh;
    logic [ID_W-1:0]    w_gnt;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0]   w_mux_a;
    logic [WIDTH-1:0]   w_mux_b;
    logic               w_mux_ci;
    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_ci;
    logic [WIDTH:0]     w_sum;

    logic [ID_W-1:0]    w_id_chain [NUM_REQ+1];
    logic [WIDTH-1:0]   w_a_chain  [NUM_REQ+1];
    logic [WIDTH-1:0]   w_b_chain  [NUM_REQ+1];
    logic               w_ci_chain [NUM_REQ+1];

    assign w_s2_adv = !r_rsp_valid || bus.rsp_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;
    assign w_accept = w_s1_adv && (|bus.req_valid);

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    assign w_hi_req = bus.req_valid & w_above;
    assign w_pick   = (|w_hi_req) ? w_hi_req : bus.req_valid;
    assign w_oh     = w_pick & (~w_pick + NUM_REQ'(1));

    assign w_id_chain[0] = '0;
    assign w_a_chain[0]  = '0;
    assign w_b_chain[0]  = '0;
    assign w_ci_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_above[gi]       = (ID_W'(gi) >= r_ptr);
            assign w_id_chain[gi+1]  = w_id_chain[gi] | (w_oh[gi] ? ID_W'(gi) : '0);
            assign w_a_chain[gi+1]   = w_a_chain[gi] | ({WIDTH{w_oh[gi]}} & bus.req_a[gi*WIDTH +: WIDTH]);
            assign w_b_chain[gi+1]   = w_b_chain[gi] | ({WIDTH{w_oh[gi]}} & bus.req_b[gi*WIDTH +: WIDTH]);
            assign w_ci_chain[gi+1]  = w_ci_chain[gi] | (w_oh[gi] & bus.req_ci[gi]);
        end
    endgenerate

    assign w_gnt     = w_id_chain[NUM_REQ];
    assign w_mux_a   = w_a_chain[NUM_REQ];
    assign w_mux_b   = w_b_chain[NUM_REQ];
    assign w_mux_ci  = w_ci_chain[NUM_REQ];
    assign w_ptr_nxt = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);

    // Ready is held low throughout reset even though it is combinational.
    assign bus.req_ready = (rst_n && w_accept) ? w_oh : '0;

`ifdef SHARED_ADD_OPISO_EN
    assign w_add_a  = r_s1_v ? r_s1_a : '0;
    assign w_add_b  = r_s1_v ? r_s1_b : '0;
    assign w_add_ci = r_s1_v & r_s1_ci;
`else
    assign w_add_a  = r_s1_a;
    assign w_add_b  = r_s1_b;
    assign w_add_ci = r_s1_ci;
`endif

    assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_ci};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_s1_v  <= 1'b0;
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_s1_ci <= 1'b0;
            r_s1_id <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_s1_adv) begin
                r_s1_v <= w_accept;
            end
`ifdef SHARED_ADD_OPISO_EN
            if (w_accept) begin
`else
            if (w_s1_adv) begin
`endif
                r_s1_a  <= w_mux_a;
                r_s1_b  <= w_mux_b;
                r_s1_ci <= w_mux_ci;
                r_s1_id <= w_gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_co    <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            if (w_s2_adv) begin
                r_rsp_valid <= r_s1_v;
            end
`ifdef SHARED_ADD_OPISO_EN
            if (w_s2_adv && r_s1_v) begin
`else
            if (w_s2_adv) begin
`endif
                r_rsp_sum <= w_sum[WIDTH-1:0];
                r_rsp_co  <= w_sum[WIDTH];
                r_rsp_id  <= r_s1_id;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_co    = r_rsp_co;
    assign bus.rsp_id    = r_rsp_id;
endmodule
`default_nettype wire

// File: tb/tb_shared_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shared_add_arbiter                                        |
// | Description : Directed scoreboard bench for shared_add_arbiter.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shared_add_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] sum;
        logic             co;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    logic [WIDTH-1:0] fair_sum [NUM_REQ];
    logic             fair_co  [NUM_REQ];

    shared_add_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

    shared_add_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: a response transfers on the posedge following this negedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d sum 0x%0h co %0b, expected no response",
                         bus.rsp_id, bus.rsp_sum, bus.rsp_co);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id",  32'(bus.rsp_id),  32'(mon_e.id));
                check("rsp_sum", 32'(bus.rsp_sum), 32'(mon_e.sum));
                check("rsp_co",  32'(bus.rsp_co),  32'(mon_e.co));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
        bus.req_ci[i]               = ci;
    endtask

    task automatic expect_ready(input string name, input logic [NUM_REQ-1:0] exp);
        @(negedge clk);
        check(name, 32'(bus.req_ready), 32'(exp));
    endtask

    task automatic push(input logic [ID_W-1:0] id, input logic [WIDTH-1:0] sum, input logic co);
        exp_q.push_back(rsp_t'{id: id, sum: sum, co: co});
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        tick();
        while (exp_q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fair_sum = '{8'h03, 8'h34, 8'h14, 8'h10};
        fair_co  = '{1'b0, 1'b0, 1'b1, 1'b1};

        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ci    = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_sum",   32'(bus.rsp_sum),   32'd0);
        check("reset_rsp_co",    32'(bus.rsp_co),    32'd0);
        check("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
        tick();
        bus.req_valid = '0;
        rst_n         = 1'b1;
        tick();

        // Single request, latency of two edges
        set_req(2, 8'h12, 8'h34, 1'b1);
        bus.req_valid = 4'b0100;
        push(2'd2, 8'h47, 1'b0);
        expect_ready("single_grant", 4'b0100);
        check("single_lat0", 32'(bus.rsp_valid), 32'd0);
        tick();
        bus.req_valid = 4'b0000;
        expect_ready("single_drop", 4'b0000);
        check("single_lat1", 32'(bus.rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        check("single_lat2", 32'(bus.rsp_valid), 32'd1);
        drain("single_drain");

        // Fresh reset, then fair rotation with all requesters active
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(0, 8'h01, 8'h02, 1'b0);
        set_req(1, 8'h22, 8'h11, 1'b1);
        set_req(2, 8'h83, 8'h90, 1'b1);
        set_req(3, 8'hF0, 8'h20, 1'b0);
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            push(ID_W'(c % NUM_REQ), fair_sum[c % NUM_REQ], fair_co[c % NUM_REQ]);
            expect_ready("fair_grant", 4'(1 << (c % NUM_REQ)));
            tick();
        end
        bus.req_valid = 4'b0000;
        drain("fair_drain");

        // Carry and wrap boundaries
        set_req(1, 8'hFF, 8'h01, 1'b0);
        bus.req_valid = 4'b0010;
        push(2'd1, 8'h00, 1'b1);
        expect_ready("carry_grant0", 4'b0010);
        tick();
        set_req(1, 8'hFF, 8'hFF, 1'b1);
        push(2'd1, 8'hFF, 1'b1);
        expect_ready("carry_grant1", 4'b0010);
        tick();
        bus.req_valid = 4'b0000;
        drain("carry_drain");

        // Backpressure: two results buffered, new requester blocked
        bus.rsp_ready = 1'b0;
        set_req(0, 8'h05, 8'h06, 1'b0);
        set_req(1, 8'h80, 8'h80, 1'b1);
        set_req(2, 8'h7F, 8'h00, 1'b1);
        bus.req_valid = 4'b0011;
        push(2'd0, 8'h0B, 1'b0);
        expect_ready("bp_grant0", 4'b0001);
        tick();
        bus.req_valid = 4'b0010;
        push(2'd1, 8'h01, 1'b1);
        expect_ready("bp_grant1", 4'b0010);
        tick();
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            expect_ready("bp_stall_ready", 4'b0000);
            check("bp_stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_stall_id",    32'(bus.rsp_id),    32'd0);
            check("bp_stall_sum",   32'(bus.rsp_sum),   32'h0B);
            tick();
        end
        bus.rsp_ready = 1'b1;
        push(2'd2, 8'h80, 1'b0);
        expect_ready("bp_resume", 4'b0100);
        tick();
        bus.req_valid = 4'b0000;
        drain("bp_drain");

        // Reset with two results in flight
        bus.rsp_ready = 1'b0;
        set_req(3, 8'h11, 8'h11, 1'b0);
        set_req(1, 8'h22, 8'h22, 1'b0);
        bus.req_valid = 4'b1010;
        expect_ready("rst_grant3", 4'b1000);
        tick();
        bus.req_valid = 4'b0010;
        expect_ready("rst_grant1", 4'b0010);
        tick();
        set_req(1, 8'h40, 8'h0A, 1'b0);
        set_req(2, 8'hAA, 8'h55, 1'b1);
        bus.req_valid = 4'b0110;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_rsp_sum",   32'(bus.rsp_sum),   32'd0);
        check("midrst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        push(2'd1, 8'h4A, 1'b0);
        expect_ready("rst_first_grant", 4'b0010);
        tick();
        bus.req_valid = 4'b0100;
        push(2'd2, 8'h00, 1'b1);
        expect_ready("rst_second_grant", 4'b0100);
        tick();
        bus.req_valid = 4'b0000;
        drain("rst_drain");

`ifdef SHARED_ADD_OPISO_EN
        // Idle operand changes must not disturb the last result
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                set_req(i, 8'(8'h31 * (c + i + 1)), 8'(8'h17 * (c + 2)), 1'b1);
            end
            @(negedge clk);
            check("iso_valid", 32'(bus.rsp_valid), 32'd0);
            check("iso_sum",   32'(bus.rsp_sum),   32'h00);
            check("iso_co",    32'(bus.rsp_co),    32'd1);
            check("iso_id",    32'(bus.rsp_id),    32'd2);
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
